wb_p2p_slave_mem: RTL and testbench
===================================

// Module: wb_p2p_slave_mem
// PURPOSE
//  Wishbone point-to-point slave: byte-addressable memory target sitting directly
//  downstream of the wishbone master modport, consuming its cyc/stb requests.
//  Classic (non-pipelined) cycles with programmable wait states; ack/err/rty responses.
//  Serves as DUT-side endpoint for bus agents and MAC register/buffer models.
// PARAMETERS
//  DATA_WIDTH   32    data bus width, 8..64, power of 2
//  ADDR_WIDTH   32    byte address width
//  MEM_WORDS    1024  memory depth in DATA_WIDTH words
//  BASE_ADDR    0     byte address of word 0; must be DATA_WIDTH/8 aligned
//  WAIT_STATES  1     cycles inserted between request capture and response, 0..15
//  RTY_PERIOD   8     every RTY_PERIOD-th accepted request gets rty (WB_SLV_RTY_EN only)
// PORTS
//  clk    in   1           bus clock
//  rst    in   1           reset; synchronous, active-low (0 = reset)
//  wdata  in   DATA_WIDTH  write data
//  adr    in   ADDR_WIDTH  byte address
//  sel    in   8           byte lane enables; bits >= DATA_WIDTH/8 ignored
//  cyc    in   1           bus cycle in progress
//  stb    in   1           strobe, request valid
//  we     in   1           1 = write, 0 = read
//  lock   in   1           ignored (point-to-point)
//  rdata  out  DATA_WIDTH  read data, valid only while ack=1
//  ack    out  1           normal termination
//  err    out  1           error termination
//  rty    out  1           retry termination
// BEHAVIOUR
//  Reset (rst==0 at posedge): state=IDLE, ack=err=rty=0, rdata=0, wait/rty counters=0;
//   memory contents NOT cleared. Reset mid-cycle drops the request, no write, no response.
//  FSM IDLE -> WAIT -> RESP -> IDLE:
//   IDLE: cyc&stb at posedge -> capture adr/wdata/sel/we; WAIT_STATES==0 ? RESP : WAIT.
//   WAIT: count WAIT_STATES cycles, then RESP. cyc==0 in WAIT -> abort to IDLE, no write.
//   RESP: exactly one of ack/err/rty high for one cycle; then IDLE.
//  Latency: request sampled at edge N -> response visible after edge N+1+WAIT_STATES.
//  Back-to-back: after RESP, IDLE accepts a new request at the next edge (one idle cycle
//   min); a stb still high in that IDLE is a NEW request.
//  Decode: off = adr-BASE_ADDR (unsigned); err if adr<BASE_ADDR, off>=MEM_WORDS*DATA_WIDTH/8,
//   or adr low log2(DATA_WIDTH/8) bits !=0. err: no write, rdata=0.
//  Write: performed in RESP cycle for lanes with sel[i]=1; sel==0 write acks, no change.
//  Read: rdata = full word regardless of sel; driven only with ack, else 0.
//  Precedence in RESP: err > rty > ack. stb/cyc/adr changes after capture ignored.
// CONFIGURATION
//  WB_SLV_RTY_EN defined: 0..RTY_PERIOD-1 counter increments per decoded-valid request;
//   at RTY_PERIOD-1 response is rty (no write, rdata=0), counter wraps to 0.
//  Undefined: rty tied 0, no counter logic.
// STRUCTURE
//  Package wb_slv_pkg: state_e {IDLE,WAIT,RESP}, resp_e {RSP_ACK,RSP_ERR,RSP_RTY},
//   lane count function, WAIT_CNT_W constant.
//  Sub-module wb_slv_mem_array: single-port byte-enable RAM (MEM_WORDS x DATA_WIDTH),
//   combinational read, registered write.
// TESTING
//  1 write adr=0x10 wdata=0xDEADBEEF sel=0xF, read back -> ack after 2 cycles (WS=1), rdata=0xDEADBEEF
//  2 write 0x11223344 sel=0x5 over 0xDEADBEEF -> read returns 0xDE22BE44
//  3 read adr=0x1000 (MEM_WORDS=1024) and adr=0x2 -> err=1, ack=0, rdata=0; memory unchanged
//  4 drop cyc in WAIT (WS=3) during write to 0x20 -> no response; later read 0x20 unchanged
//  5 WB_SLV_RTY_EN, 16 valid writes -> requests 8 and 16 get rty, their data not stored
//  6 rst=0 in WAIT of a write -> ack/err/rty=0 next cycle, FSM IDLE, target word unchanged

Source files
------------

// File: rtl/wb_slv_pkg.sv
// Shared types and helpers for the Wishbone point-to-point memory slave.
// Optional feature macro used by the slave: WB_SLV_RTY_EN (periodic retry responses).
package wb_slv_pkg;

    // Bus-cycle sequencing: capture, wait-state countdown, single-cycle response
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    // Termination kind chosen for the captured request
    typedef enum logic [1:0] {
        RSP_ACK = 2'd0,
        RSP_ERR = 2'd1,
        RSP_RTY = 2'd2
    } resp_e;

    // Wide enough for WAIT_STATES up to 15
    localparam int WAIT_CNT_W = 4;

    // Number of byte lanes on a data bus of the given width
    function automatic int lane_count(input int data_width);
        return data_width / 8;
    endfunction

    // Index width for a table of the given depth, never narrower than one bit
    function automatic int clog2_min1(input int value);
        int bits;
        bits = $clog2(value);
        if (bits < 1) begin
            bits = 1;
        end
        return bits;
    endfunction

endpackage

// File: rtl/wb_slv_mem_array.sv
// Single-port byte-enable RAM: combinational read, registered per-lane write.
// Contents are intentionally not reset.
module wb_slv_mem_array
    import wb_slv_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_WORDS  = 1024,
    parameter int LANES      = DATA_WIDTH / 8,
    parameter int IDX_W      = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [LANES-1:0]      be,
    input  logic [IDX_W-1:0]      addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_r [MEM_WORDS];

    // Byte-lane write of the addressed word
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < LANES; i++) begin
                if (be[i]) begin
                    mem_r[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = mem_r[addr];

endmodule

// File: rtl/wb_p2p_slave_mem.sv
// Wishbone classic point-to-point slave with a byte-addressable memory behind it.
// Requests are captured in IDLE, held for WAIT_STATES cycles, then terminated
// with exactly one of ack/err/rty for a single cycle.
// Optional feature: define WB_SLV_RTY_EN to answer every RTY_PERIOD-th decoded-valid
// request with rty instead of ack.
module wb_p2p_slave_mem
    import wb_slv_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    MEM_WORDS   = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int                    WAIT_STATES = 1,
    parameter int                    RTY_PERIOD  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] adr,
    input  logic [7:0]            sel,
    input  logic                  cyc,
    input  logic                  stb,
    input  logic                  we,
    input  logic                  lock,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  ack,
    output logic                  err,
    output logic                  rty
);

    localparam int                    LANES     = lane_count(DATA_WIDTH);
    localparam int                    LANE_BITS = $clog2(LANES);
    localparam int                    IDX_W     = clog2_min1(MEM_WORDS);
    localparam logic [ADDR_WIDTH-1:0] LANE_MASK = ADDR_WIDTH'(LANES - 1);
    localparam logic [63:0]           MEM_BYTES = 64'(MEM_WORDS) * 64'(LANES);
    localparam logic [WAIT_CNT_W-1:0] WS_LAST   = WAIT_CNT_W'(WAIT_STATES - 1);

    state_e                  state_r;
    logic [WAIT_CNT_W-1:0]   wait_cnt_r;
    logic [IDX_W-1:0]        idx_r;
    logic [DATA_WIDTH-1:0]   wdata_r;
    logic [LANES-1:0]        sel_r;
    logic                    we_r;
    logic                    dec_err_r;
    logic                    ack_r;
    logic                    err_r;
    logic                    rty_r;
    logic [DATA_WIDTH-1:0]   rdata_r;

    logic [ADDR_WIDTH-1:0]   off_s;
    logic [63:0]             off_ext_s;
    logic                    dec_err_s;
    logic [IDX_W-1:0]        idx_s;
    logic                    rty_hit_s;
    resp_e                   resp_s;
    logic                    mem_we_s;
    logic [DATA_WIDTH-1:0]   mem_rdata_s;
    logic                    unused_s;

    // Address decode of the live request: window check, alignment check, word index
    always_comb begin
        off_s     = adr - BASE_ADDR;
        off_ext_s = 64'(off_s);
        dec_err_s = (adr < BASE_ADDR)
                 || (off_ext_s >= MEM_BYTES)
                 || ((adr & LANE_MASK) != {ADDR_WIDTH{1'b0}});
        idx_s     = IDX_W'(off_s >> LANE_BITS);
    end

`ifdef WB_SLV_RTY_EN
    localparam int               RTY_W    = clog2_min1(RTY_PERIOD);
    localparam logic [RTY_W-1:0] RTY_LAST = RTY_W'(RTY_PERIOD - 1);

    logic [RTY_W-1:0] rty_cnt_r;

    // Retry is due when the counter has reached its last slot
    always_comb begin
        rty_hit_s = (rty_cnt_r == RTY_LAST);
    end

    // Count completed decoded-valid requests, wrapping after the retried one
    always_ff @(posedge clk) begin
        if (!rst) begin
            rty_cnt_r <= {RTY_W{1'b0}};
        end else if ((state_r == RESP) && !dec_err_r) begin
            if (rty_hit_s) begin
                rty_cnt_r <= {RTY_W{1'b0}};
            end else begin
                rty_cnt_r <= rty_cnt_r + {{(RTY_W-1){1'b0}}, 1'b1};
            end
        end
    end
`else
    // Retry feature absent: never retry
    always_comb begin
        rty_hit_s = 1'b0;
    end
`endif

    // Termination choice for the captured request: err beats rty beats ack
    always_comb begin
        resp_s = RSP_ACK;
        if (dec_err_r) begin
            resp_s = RSP_ERR;
        end else if (rty_hit_s) begin
            resp_s = RSP_RTY;
        end else begin
            resp_s = RSP_ACK;
        end
    end

    // Memory is written only on the response edge of an acked write, never under reset
    always_comb begin
        mem_we_s = 1'b0;
        if (rst && (state_r == RESP) && (resp_s == RSP_ACK) && we_r) begin
            mem_we_s = 1'b1;
        end else begin
            mem_we_s = 1'b0;
        end
    end

    wb_slv_mem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_WORDS  (MEM_WORDS),
        .LANES      (LANES),
        .IDX_W      (IDX_W)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we_s),
        .be    (sel_r),
        .addr  (idx_r),
        .wdata (wdata_r),
        .rdata (mem_rdata_s)
    );

    // Bus-cycle FSM with registered terminations and read data
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r    <= IDLE;
            wait_cnt_r <= {WAIT_CNT_W{1'b0}};
            idx_r      <= {IDX_W{1'b0}};
            wdata_r    <= {DATA_WIDTH{1'b0}};
            sel_r      <= {LANES{1'b0}};
            we_r       <= 1'b0;
            dec_err_r  <= 1'b0;
            ack_r      <= 1'b0;
            err_r      <= 1'b0;
            rty_r      <= 1'b0;
            rdata_r    <= {DATA_WIDTH{1'b0}};
        end else begin
            ack_r   <= 1'b0;
            err_r   <= 1'b0;
            rty_r   <= 1'b0;
            rdata_r <= {DATA_WIDTH{1'b0}};
            case (state_r)
                IDLE: begin
                    if (cyc && stb) begin
                        idx_r      <= idx_s;
                        wdata_r    <= wdata;
                        sel_r      <= sel[LANES-1:0];
                        we_r       <= we;
                        dec_err_r  <= dec_err_s;
                        wait_cnt_r <= {WAIT_CNT_W{1'b0}};
                        state_r    <= (WAIT_STATES == 0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    // Master abandoning the cycle drops the request silently
                    if (!cyc) begin
                        state_r <= IDLE;
                    end else if (wait_cnt_r == WS_LAST) begin
                        state_r <= RESP;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + {{(WAIT_CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                RESP: begin
                    case (resp_s)
                        RSP_ACK: begin
                            ack_r   <= 1'b1;
                            rdata_r <= we_r ? {DATA_WIDTH{1'b0}} : mem_rdata_s;
                        end
                        RSP_ERR: err_r <= 1'b1;
                        RSP_RTY: rty_r <= 1'b1;
                        default: err_r <= 1'b1;
                    endcase
                    state_r <= IDLE;
                end
                default: state_r <= IDLE;
            endcase
        end
    end

    assign ack   = ack_r;
    assign err   = err_r;
    assign rty   = rty_r;
    assign rdata = rdata_r;

    // lock has no meaning on a point-to-point link; upper sel lanes may be unused
    assign unused_s = ^{lock, sel, 32'(RTY_PERIOD)};

endmodule

// File: tb/tb_wb_p2p_slave_mem.sv
// Randomized self-checking bench for wb_p2p_slave_mem against a transaction-level model.
module tb_wb_p2p_slave_mem;

    localparam int          WS    = 3;
    localparam int          WORDS = 1024;
    localparam int          RP    = 8;
    localparam logic [31:0] BASE  = 32'h0000_0000;
`ifdef WB_SLV_RTY_EN
    localparam bit RTY_EN = 1'b1;
`else
    localparam bit RTY_EN = 1'b0;
`endif
    localparam logic [1:0] K_ACK = 2'd0;
    localparam logic [1:0] K_ERR = 2'd1;
    localparam logic [1:0] K_RTY = 2'd2;

    logic        clk;
    logic        rst;
    logic [31:0] wdata;
    logic [31:0] adr;
    logic [7:0]  sel;
    logic        cyc;
    logic        stb;
    logic        we;
    logic        lock;
    logic [31:0] rdata;
    logic        ack;
    logic        err;
    logic        rty;

    wb_p2p_slave_mem #(
        .DATA_WIDTH  (32),
        .ADDR_WIDTH  (32),
        .MEM_WORDS   (WORDS),
        .BASE_ADDR   (BASE),
        .WAIT_STATES (WS),
        .RTY_PERIOD  (RP)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .wdata (wdata),
        .adr   (adr),
        .sel   (sel),
        .cyc   (cyc),
        .stb   (stb),
        .we    (we),
        .lock  (lock),
        .rdata (rdata),
        .ack   (ack),
        .err   (err),
        .rty   (rty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    bit          chk_en = 1'b0;
    logic        exp_ack, exp_err, exp_rty;
    logic [31:0] exp_rdata;
    logic [31:0] mdl [WORDS];
    int          rty_cnt_m;
    logic [1:0]  kind_v;
    logic [31:0] bad_adr [5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, want, $time);
        end
    endtask

    // Every cycle: DUT outputs must equal what the model says is visible now
    always @(negedge clk) begin
        if (chk_en) begin
            check("ack",   {63'd0, ack}, {63'd0, exp_ack});
            check("err",   {63'd0, err}, {63'd0, exp_err});
            check("rty",   {63'd0, rty}, {63'd0, exp_rty});
            check("rdata", {32'd0, rdata}, {32'd0, exp_rdata});
        end
    end

    task automatic clear_exp();
        exp_ack = 1'b0; exp_err = 1'b0; exp_rty = 1'b0; exp_rdata = 32'd0;
    endtask

    // Transaction-level rules: decode, periodic retry, lane merge, read value
    task automatic model_resp(input logic w, input logic [31:0] a, input logic [31:0] d,
                              input logic [7:0] s, output logic [1:0] kind, output logic [31:0] rd);
        longint unsigned off;
        int idx;
        off = longint'(a) - longint'(BASE);
        rd = 32'd0;
        if (a < BASE || off >= longint'(WORDS * 4) || (a % 4) != 0) begin
            kind = K_ERR;
        end else if (RTY_EN && rty_cnt_m == RP - 1) begin
            kind = K_RTY;
            rty_cnt_m = 0;
        end else begin
            kind = K_ACK;
            if (RTY_EN) rty_cnt_m++;
            idx = int'(off / 4);
            if (w) begin
                for (int i = 0; i < 4; i++) begin
                    if (s[i]) mdl[idx][8*i +: 8] = d[8*i +: 8];
                end
            end else begin
                rd = mdl[idx];
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            clear_exp();
        end
    endtask

    // One bus request; abort_k in 0..WS-1 drops cyc before that wait edge
    task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [7:0] s, input int abort_k, output logic [1:0] kind);
        logic [31:0] rd;
        kind = 2'd3;
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdata = d; sel = s;
        @(posedge clk); #1;
        clear_exp();
        stb = 1'($urandom); adr = $urandom; wdata = $urandom; sel = 8'($urandom); we = 1'($urandom);
        for (int k = 0; k < WS; k++) begin
            if (k == abort_k) begin
                cyc = 1'b0; stb = 1'b0;
                @(posedge clk); #1;
                return;
            end
            @(posedge clk); #1;
        end
        model_resp(w, a, d, s, kind, rd);
        @(posedge clk); #1;
        exp_ack = (kind == K_ACK);
        exp_err = (kind == K_ERR);
        exp_rty = (kind == K_RTY);
        exp_rdata = rd;
        cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = 32'd0; wdata = 32'd0; sel = 8'd0;
    endtask

    task automatic pulse_reset();
        rst = 1'b0;
        @(posedge clk); #1;
        clear_exp();
        rst = 1'b1;
        rty_cnt_m = 0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = 32'd0; wdata = 32'd0;
        sel = 8'd0; lock = 1'b0; rty_cnt_m = 0;
        clear_exp();
        bad_adr[0] = 32'h0000_1000; bad_adr[1] = 32'h0000_0002; bad_adr[2] = 32'h0000_1003;
        bad_adr[3] = 32'hFFFF_FFFC; bad_adr[4] = 32'h0000_0FFF;
        repeat (3) @(posedge clk);
        #1;
        chk_en = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;

        // Known contents for every word the bench will read
        for (int wd = 0; wd < 40; wd++) begin
            int a;
            a = (wd < 32) ? wd * 4 : (WORDS - 40 + wd) * 4;
            kind_v = K_RTY;
            while (kind_v != K_ACK) txn(1'b1, 32'(a), $urandom, 8'hFF, -1, kind_v);
        end

        // Full write then read-back
        pulse_reset();
        txn(1'b1, 32'h10, 32'hDEADBEEF, 8'h0F, -1, kind_v);
        txn(1'b0, 32'h10, 32'd0, 8'h0F, -1, kind_v);
        @(negedge clk);
        check("t1_rdata", {32'd0, rdata}, {32'd0, 32'hDEADBEEF});
        check("t1_ack", {63'd0, ack}, 64'd1);

        // Partial lanes merge into the old word
        txn(1'b1, 32'h10, 32'h11223344, 8'h05, -1, kind_v);
        txn(1'b0, 32'h10, 32'd0, 8'h0F, -1, kind_v);
        @(negedge clk);
        check("t2_rdata", {32'd0, rdata}, {32'd0, 32'hDE22BE44});
        check("t2_model", {32'd0, mdl[4]}, {32'd0, 32'hDE22BE44});

        // Out-of-window and misaligned accesses
        txn(1'b0, 32'h1000, 32'd0, 8'h0F, -1, kind_v);
        @(negedge clk);
        check("t3_oob", {31'd0, err, ack, rdata}, {31'd0, 1'b1, 1'b0, 32'd0});
        txn(1'b1, 32'h2, 32'h0BADF00D, 8'h0F, -1, kind_v);
        @(negedge clk);
        check("t3_misalign", {31'd0, err, ack, rdata}, {31'd0, 1'b1, 1'b0, 32'd0});
        txn(1'b0, 32'h0, 32'd0, 8'h0F, -1, kind_v);

        // Abandoned write leaves memory alone
        txn(1'b1, 32'h20, 32'h55AA55AA, 8'h0F, 1, kind_v);
        idle(2);
        txn(1'b0, 32'h20, 32'd0, 8'h0F, -1, kind_v);

        // Reset while a write is waiting
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h30; wdata = 32'hCAFEF00D; sel = 8'h0F;
        @(posedge clk); #1;
        clear_exp();
        stb = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1; cyc = 1'b0; rty_cnt_m = 0;
        idle(1);
        txn(1'b0, 32'h30, 32'd0, 8'h0F, -1, kind_v);

        // Sixteen valid writes: retry slots 8 and 16 when retries are enabled
        pulse_reset();
        for (int i = 0; i < 16; i++) begin
            txn(1'b1, 32'(i * 4), 32'hA500_0000 | 32'(i), 8'h0F, -1, kind_v);
            @(negedge clk);
            check("t5_rty", {63'd0, rty}, {63'd0, (RTY_EN && (i == 7 || i == 15))});
        end
        for (int i = 0; i < 16; i++) txn(1'b0, 32'(i * 4), 32'd0, 8'h00, -1, kind_v);

        // Randomized traffic with gaps, back-to-back requests and aborts
        for (int n = 0; n < 400; n++) begin
            logic [31:0] a;
            int ab;
            if ($urandom_range(0, 99) < 85) begin
                int wd;
                wd = int'($urandom_range(0, 39));
                a = (wd < 32) ? 32'(wd * 4) : 32'((WORDS - 40 + wd) * 4);
            end else begin
                a = bad_adr[$urandom_range(0, 4)];
            end
            ab = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, WS - 1)) : -1;
            lock = 1'($urandom);
            txn(1'($urandom), a, $urandom, 8'($urandom), ab, kind_v);
            idle(int'($urandom_range(0, 2)));
        end
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
